// File: rtl/sqrt_arbiter_pkg.sv
// Shared definitions for the square-root arbiter: FSM state encoding and
// the helper that sizes requester indices.
package sqrt_arbiter_pkg;

    typedef enum logic [2:0] {
        DRAIN,
        IDLE,
        ISSUE,
        BUSY,
        RESP
    } state_t;

    localparam int MAX_REQ = 16;

    // A single requester still needs a one-bit index.
    function automatic int grant_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sqrt_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or after ptr,
// searching upward and wrapping past the last requester.
module rr_arbiter
    import sqrt_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = grant_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   grant
);

    function automatic logic [IDX_W-1:0] wrap_index(input logic [IDX_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDX_W'(sum);
    endfunction

    // Walking the offsets downward lets the smallest offset from ptr win.
    always_comb begin
        valid = 1'b0;
        grant = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (eligible[wrap_index(ptr, k)]) begin
                valid = 1'b1;
                grant = wrap_index(ptr, k);
            end
        end
    end

endmodule

// File: rtl/sqrt_arbiter.sv
// Shares one iterative square-root unit among NUM_REQ requesters, round-robin.
// Define SQRT_ARBITER_ASSERT_EN to build in simulation-only protocol checks.
module sqrt_arbiter
    import sqrt_arbiter_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int NUM_REQ      = 4,
    parameter int DRAIN_CYCLES = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_go,
    input  logic [NUM_REQ*WIDTH-1:0] req_in,
    output logic [NUM_REQ*WIDTH-1:0] req_out,
    output logic [NUM_REQ-1:0]       req_done,
    output logic                     sq_go,
    output logic [WIDTH-1:0]         sq_in,
    input  logic [WIDTH-1:0]         sq_out,
    input  logic                     sq_done
);

    localparam int IDX_W = grant_width(NUM_REQ);
    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     drain_cnt;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     grant;
    logic [IDX_W-1:0]     arb_grant;
    logic                 arb_valid;
    logic [NUM_REQ-1:0]   served;
    logic [NUM_REQ-1:0]   eligible;
    logic [WIDTH-1:0]     operand [NUM_REQ];
    logic [WIDTH-1:0]     result  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign operand[i]                 = req_in[i*WIDTH +: WIDTH];
        assign req_out[i*WIDTH +: WIDTH]  = result[i];
    end

    // A requester that already got its answer stays out until it drops go.
    assign eligible = req_go & ~served;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .eligible (eligible),
        .ptr      (ptr),
        .valid    (arb_valid),
        .grant    (arb_grant)
    );

    always_comb begin
        state_next = state;
        sq_go      = 1'b0;
        req_done   = '0;
        case (state)
            DRAIN: begin
                if (drain_cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (arb_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                sq_go      = 1'b1;
                state_next = BUSY;
            end
            BUSY: begin
                if (sq_done) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                req_done[grant] = 1'b1;
                state_next      = IDLE;
            end
            default: state_next = DRAIN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= DRAIN;
            drain_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == DRAIN) begin
                drain_cnt <= drain_cnt + CNT_W'(1);
            end
        end
    end

    // Operand is latched at grant time so later req_in changes cannot leak in.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr    <= '0;
            grant  <= '0;
            served <= '0;
            sq_in  <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                result[i] <= '0;
            end
        end else begin
            served <= (served | req_done) & req_go;
            if (state == IDLE && arb_valid) begin
                grant <= arb_grant;
                sq_in <= operand[arb_grant];
                ptr   <= (int'(arb_grant) == NUM_REQ - 1) ? '0 : arb_grant + IDX_W'(1);
            end
            if (state == BUSY && sq_done) begin
                result[grant] <= sq_out;
            end
        end
    end

`ifdef SQRT_ARBITER_ASSERT_EN
    logic [NUM_REQ*WIDTH-1:0] req_out_prev;
    logic                     check_armed;

    // The armed flag skips the cycle after reset, when req_out legitimately clears.
    always_ff @(posedge clk) begin
        req_out_prev <= req_out;
        check_armed  <= !reset;
        if (!reset) begin
            if (sq_done && state != BUSY && state != DRAIN) begin
                $error("sqrt_arbiter: sq_done outside BUSY");
            end
            if ($countones(req_done) > 1) begin
                $error("sqrt_arbiter: more than one req_done bit high");
            end
            if (check_armed) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_out[i*WIDTH +: WIDTH] != req_out_prev[i*WIDTH +: WIDTH] && !req_done[i]) begin
                        $error("sqrt_arbiter: req_out slice %0d changed without req_done", i);
                    end
                end
            end
        end
    end
`else
    // Default build carries no checks.
`endif

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Self-checking bench for sqrt_arbiter with a 16-cycle floor-sqrt unit model
// and a scoreboard holding results in the expected service order.
module tb_sqrt_arbiter;

    localparam int WIDTH        = 32;
    localparam int NUM_REQ      = 4;
    localparam int DRAIN_CYCLES = 32;
    localparam int SQ_LAT       = 16;

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] value;
    } exp_t;

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] operand;
        logic [WIDTH-1:0] expected;
    } vec_t;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic [NUM_REQ-1:0]       req_go = '0;
    logic [NUM_REQ*WIDTH-1:0] req_in = '0;
    logic [NUM_REQ*WIDTH-1:0] req_out;
    logic [NUM_REQ-1:0]       req_done;
    logic                     sq_go;
    logic [WIDTH-1:0]         sq_in;
    logic [WIDTH-1:0]         sq_out;
    logic                     sq_done;

    logic                     model_busy = 1'b0;
    logic                     model_done = 1'b0;
    logic [WIDTH-1:0]         model_out = '0;
    logic [WIDTH-1:0]         model_arg = '0;
    int                       model_cnt = 0;
    logic                     inject_done = 1'b0;
    logic [WIDTH-1:0]         inject_val = '0;

    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;
    int   sq_go_count = 0;
    int   last_sq_go_cycle = -1;
    int   last_sq_done_cycle = -1;
    int   done_count = 0;
    int   last_done_cycle = -1;
    int   last_done_idx = -1;
    exp_t sb[$];
    vec_t vecs[8];

    int rel, t0, g_snap, d_snap, dbase, expect_idx, j;

    sqrt_arbiter #(
        .WIDTH        (WIDTH),
        .NUM_REQ      (NUM_REQ),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_go   (req_go),
        .req_in   (req_in),
        .req_out  (req_out),
        .req_done (req_done),
        .sq_go    (sq_go),
        .sq_in    (sq_in),
        .sq_out   (sq_out),
        .sq_done  (sq_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [WIDTH-1:0] isqrt(input logic [WIDTH-1:0] x);
        logic [63:0] r;
        logic [63:0] t;
        r = 64'd0;
        for (int b = WIDTH/2 - 1; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= {32'd0, x}) r = t;
        end
        return r[WIDTH-1:0];
    endfunction

    // Shared unit model: keeps running across DUT reset, like real hardware.
    always @(posedge clk) begin
        model_done <= 1'b0;
        if (model_busy) begin
            if (model_cnt == 1) begin
                model_done <= 1'b1;
                model_out  <= isqrt(model_arg);
                model_busy <= 1'b0;
            end else begin
                model_cnt <= model_cnt - 1;
            end
        end else if (sq_go === 1'b1) begin
            model_busy <= 1'b1;
            model_arg  <= sq_in;
            model_cnt  <= SQ_LAT - 1;
        end
    end

    assign sq_done = model_done | inject_done;
    assign sq_out  = inject_done ? inject_val : model_out;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [WIDTH-1:0] operand, input logic [WIDTH-1:0] expected);
        exp_t e;
        req_in[idx*WIDTH +: WIDTH] = operand;
        req_go[idx] = 1'b1;
        e.idx   = idx;
        e.value = expected;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (done_count >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok && done_count >= target) ok = 1'b1;
        if (!ok) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s timeout: done count %0d, required %0d", name, done_count, target);
        end
    endtask

    task automatic wait_sq_go(input int target, input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (sq_go_count >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok && sq_go_count >= target) ok = 1'b1;
        if (!ok) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s timeout: sq_go count %0d, required %0d", name, sq_go_count, target);
        end
    endtask

    // Monitor samples on the falling edge, away from the DUT's update edge.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (sq_go === 1'b1) begin
                sq_go_count++;
                last_sq_go_cycle = cycle;
            end
            if (sq_done === 1'b1) last_sq_done_cycle = cycle;
            if (req_done !== '0) begin
                int idx;
                exp_t e;
                idx = -1;
                for (int i = NUM_REQ - 1; i >= 0; i--) begin
                    if (req_done[i] === 1'b1) idx = i;
                end
                checkOutput("done_onehot", $countones(req_done), 1);
                done_count++;
                last_done_cycle = cycle;
                last_done_idx   = idx;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_done: requester %0d done with nothing pending", idx);
                end else begin
                    e = sb.pop_front();
                    checkOutput("done_index", idx, e.idx);
                    if (idx >= 0) checkOutput("done_result", req_out[idx*WIDTH +: WIDTH], e.value);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1, 32'd0,          32'd0};
        vecs[1] = '{2, 32'd1,          32'd1};
        vecs[2] = '{3, 32'd2,          32'd1};
        vecs[3] = '{0, 32'd15,         32'd3};
        vecs[4] = '{1, 32'd65536,      32'd256};
        vecs[5] = '{2, 32'd99,         32'd9};
        vecs[6] = '{0, 32'hFFFF_FFFF,  32'd65535};
        vecs[7] = '{3, 32'd1000000,    32'd1000};

        repeat (3) tick();
        checkOutput("reset_sq_go", sq_go, 0);
        checkOutput("reset_req_done", req_done, 0);
        checkOutput("reset_sq_in", sq_in, 0);
        checkOutput("reset_req_out", req_out, 0);

        // Requests raised during reset must wait out the whole drain period.
        applyStimulus(0, 32'd81, 32'd9);
        applyStimulus(2, 32'd100, 32'd10);
        reset = 1'b0;
        rel = cycle;
        wait_sq_go(1, 100, "drain_go");
        checkOutput("drain_first_go_cycle", last_sq_go_cycle, rel + DRAIN_CYCLES + 1);
        wait_done(2, 100, "simultaneous");
        req_go[0] = 1'b0;
        req_go[2] = 1'b0;
        tick();

        // ptr should now be 3, so requester 3 beats requester 0.
        applyStimulus(3, 32'd9, 32'd3);
        applyStimulus(0, 32'd1, 32'd1);
        wait_done(4, 100, "ptr_probe");
        req_go[3] = 1'b0;
        req_go[0] = 1'b0;
        tick();

        t0 = cycle;
        applyStimulus(0, 32'd16, 32'd4);
        wait_done(5, 60, "single");
        checkOutput("go_latency", last_sq_go_cycle, t0 + 1);
        checkOutput("unit_latency", last_sq_done_cycle, t0 + 1 + SQ_LAT);
        checkOutput("done_latency", last_done_cycle, last_sq_done_cycle + 1);
        req_go[0] = 1'b0;
        repeat (2) tick();
        checkOutput("req_out0_held", req_out[0 +: WIDTH], 4);

        for (int v = 0; v < 8; v++) begin
            g_snap = sq_go_count;
            d_snap = done_count;
            applyStimulus(vecs[v].idx, vecs[v].operand, vecs[v].expected);
            wait_sq_go(g_snap + 1, 10, "table_go");
            repeat (2) tick();
            req_in[vecs[v].idx*WIDTH +: WIDTH] = ~vecs[v].operand;
            tick();
            checkOutput("sq_in_stable", sq_in, vecs[v].operand);
            wait_done(d_snap + 1, 40, "table_done");
            req_go[vecs[v].idx] = 1'b0;
            repeat (2) tick();
        end

        // Fairness: operand k*k+k always has floor-sqrt k.
        dbase = done_count;
        for (int i = 0; i < NUM_REQ; i++) begin
            applyStimulus(i, (10 + i) * (10 + i) + (10 + i), 10 + i);
        end
        expect_idx = 0;
        for (int s = 0; s < 8; s++) begin
            wait_done(dbase + s + 1, 60, "fair_done");
            checkOutput("fair_order", last_done_idx, expect_idx);
            j = (last_done_idx < 0) ? expect_idx : last_done_idx;
            req_go[j] = 1'b0;
            tick();
            if (s < 4) applyStimulus(j, (20 + j) * (20 + j) + (20 + j), 20 + j);
            expect_idx = (expect_idx + 1) % NUM_REQ;
        end
        tick();

        applyStimulus(1, 32'd25, 32'd5);
        wait_done(done_count + 1, 60, "held_first");
        g_snap = sq_go_count;
        d_snap = done_count;
        repeat (5) tick();
        checkOutput("held_no_go", sq_go_count, g_snap);
        checkOutput("held_no_done", done_count, d_snap);
        req_go[1] = 1'b0;
        tick();
        applyStimulus(1, 32'd49, 32'd7);
        wait_done(d_snap + 1, 60, "held_rerun");
        req_go[1] = 1'b0;
        repeat (2) tick();

        // Abandoned request: no scoreboard entry, its late sq_done lands in DRAIN.
        g_snap = sq_go_count;
        req_in[2*WIDTH +: WIDTH] = 32'hFFFF_FFFF;
        req_go[2] = 1'b1;
        wait_sq_go(g_snap + 1, 10, "abandon_go");
        repeat (4) tick();
        reset = 1'b1;
        d_snap = done_count;
        g_snap = sq_go_count;
        repeat (2) tick();
        applyStimulus(2, 32'd144, 32'd12);
        reset = 1'b0;
        rel = cycle;
        wait_sq_go(g_snap + 1, 100, "post_reset_go");
        checkOutput("post_reset_go_cycle", last_sq_go_cycle, rel + DRAIN_CYCLES + 1);
        checkOutput("no_done_in_drain", done_count, d_snap);
        wait_done(d_snap + 1, 60, "post_reset_done");
        req_go[2] = 1'b0;
        repeat (3) tick();

        d_snap = done_count;
        g_snap = sq_go_count;
        inject_val  = 32'd1234;
        inject_done = 1'b1;
        tick();
        inject_done = 1'b0;
        repeat (4) tick();
        checkOutput("stale_no_done", done_count, d_snap);
        checkOutput("stale_no_go", sq_go_count, g_snap);
        checkOutput("stale_req_out2", req_out[2*WIDTH +: WIDTH], 12);

        applyStimulus(1, 32'd10000, 32'd100);
        wait_done(d_snap + 1, 60, "final");
        req_go[1] = 1'b0;
        repeat (2) tick();
        checkOutput("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sqrt_arbiter.md
SQRT_ARBITER -- requirements
Module: sqrt_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 SHALL have parameter NUM_REQ, default 4, meaning number of requesters (2..16).
REQ-003 SHALL have parameter DRAIN_CYCLES, default 32, meaning post-reset cycles with issue suppressed (at least the shared unit's worst-case latency).
REQ-004 SHALL have port clk  input  1  clock; one clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_go  input  NUM_REQ  per-requester level request, held until that requester's done.
REQ-007 SHALL have port req_in  input  NUM_REQ*WIDTH  flattened operands; slice i = [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_out  output  NUM_REQ*WIDTH  flattened results, slice i held until the next result for i.
REQ-009 SHALL have port req_done  output  NUM_REQ  one-cycle done pulse per requester.
REQ-010 SHALL have port sq_go  output  1  start strobe to the shared iterative square-root unit.
REQ-011 SHALL have port sq_in  output  WIDTH  operand to the shared unit.
REQ-012 SHALL have port sq_out  input  WIDTH  result from the shared unit, valid while sq_done is high.
REQ-013 SHALL have port sq_done  input  1  one-cycle completion pulse from the shared unit.

Function
REQ-014 SHALL implement FSM states DRAIN, IDLE, ISSUE, BUSY, RESP.
REQ-015 DRAIN: SHALL count DRAIN_CYCLES cycles with sq_go low, ignoring req_go and sq_done, then go to IDLE.
REQ-016 Eligibility: requester i SHALL be eligible when req_go[i]=1 and served[i]=0.
REQ-017 IDLE: with any eligible requester, SHALL grant one round-robin, latch its index and operand into sq_in, and go to ISSUE; otherwise stay in IDLE.
REQ-018 Round-robin: the search SHALL start at pointer ptr, ascending with wrap NUM_REQ-1 -> 0; after a grant to i, ptr SHALL become (i+1) mod NUM_REQ.
REQ-019 ISSUE: SHALL drive sq_go=1 for exactly one cycle with sq_in stable, then go to BUSY.
REQ-020 BUSY: SHALL keep sq_go=0 and sq_in stable; on sq_done=1, SHALL capture sq_out and go to RESP.
REQ-021 RESP: SHALL drive req_done[grant]=1 for one cycle, with req_out slice grant updated in the same cycle, set served[grant], and return to IDLE.
REQ-022 Latency: eligible request in IDLE at cycle t -> sq_go at t+1; sq_done at cycle d -> req_done at d+1.
REQ-023 served[i] SHALL clear in any cycle where req_go[i]=0, so a go held across done SHALL NOT retrigger.
REQ-024 Operand changes on req_in after the grant SHALL have no effect on the in-flight operation.
REQ-025 sq_done outside BUSY SHALL be ignored.
REQ-026 A requester dropping req_go while in flight SHALL still receive its req_done.
REQ-027 At most one req_done bit SHALL be high in any cycle.

Reset
REQ-028 Reset SHALL set state=DRAIN, drain count=0, ptr=0, served=0, req_out=0, req_done=0, sq_go=0, sq_in=0.
REQ-029 Reset mid-operation SHALL abandon the in-flight request without a req_done; the shared unit's late sq_done SHALL fall within DRAIN and be ignored.

Configuration
REQ-030 With macro SQRT_ARBITER_ASSERT_EN defined, the block SHALL include simulation checks that $error on: sq_done outside BUSY after DRAIN; more than one req_done bit high; req_out slice change without req_done.
REQ-031 Without SQRT_ARBITER_ASSERT_EN, the block SHALL contain no checks and SHALL have identical port-level behaviour.

Structure
REQ-032 Package sqrt_arbiter_pkg SHALL hold the FSM state enum and the grant-index width function/constant.
REQ-033 Round-robin selection SHALL be one sub-module rr_arbiter: combinational, with inputs eligible vector and ptr, and outputs valid and grant index.

Verification
REQ-034 Bench model of the shared unit: floor-sqrt with 16-cycle latency, go ignored while busy.
REQ-035 Single request: req_go[0]=1, in=16 -> sq_go one cycle later; req_done[0] one cycle after sq_done; req_out[0]=4.
REQ-036 Simultaneous requests: req 0 in=81, req 2 in=100, ptr=0 -> req 0 served first (9), then req 2 (10); ptr=3 afterwards.
REQ-037 Fairness: all four req_go held, each re-raised after its done -> grant order 0,1,2,3,0,...; no requester waits more than 3 services.
REQ-038 Held go: req_go[1] kept high 5 cycles past done -> no second sq_go; drop and re-raise with in=49 -> result 7.
REQ-039 Reset mid-BUSY with in=4294967295 -> no req_done; a new request is issued only after DRAIN_CYCLES; a stale sq_done pulse injected in IDLE is ignored (assertion fires only with SQRT_ARBITER_ASSERT_EN).
